bullet_fire_sched: RTL and testbench

//  Fire scheduler for the ship's bullet pool. Edge-detects shoot_up/shoot_down, rate-limits shots

---
 rtl/bullet_fire_sched_pkg.sv | 14 +
 rtl/bullet_fire_sched_slot_picker.sv | 16 +
 rtl/bullet_fire_sched.sv | 117 +++++++++++
 tb/tb_bullet_fire_sched.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/bullet_fire_sched_pkg.sv
// bullet_fire_sched_pkg: FSM state encoding, default sizing, direction codes and helpers
// for the bullet fire scheduler.
package bullet_fire_sched_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, FIRE = 2'd1, COOLDOWN = 2'd2} state_t;
  localparam int DEF_NUM_SLOTS = 4;
  localparam int DEF_COOLDOWN_FRAMES = 8;
  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DOWN = 1'b0;
  function automatic logic [2:0] onehot_idx(input logic [7:0] v);
    onehot_idx = '0;
    for (int i = 0; i < 8; i++)
      if (v[i]) onehot_idx = 3'(i);
  endfunction
endpackage

// File: rtl/bullet_fire_sched_slot_picker.sv
// bullet_fire_sched_slot_picker: combinational free-mask to one-hot slot choice.
// Ports: free (free-slot mask), start (index where the search begins, must be < NUM_SLOTS),
//        pick (one-hot chosen slot, 0 when nothing is free).
module bullet_fire_sched_slot_picker #(
  parameter int NUM_SLOTS = 4
) (
  input  logic [NUM_SLOTS-1:0] free,
  input  logic [2:0]           start,
  output logic [NUM_SLOTS-1:0] pick
);
  logic [NUM_SLOTS-1:0] rot, low;
  // Rotate so the start slot sits at bit 0, take the lowest set bit, rotate back.
  assign rot  = NUM_SLOTS'({free, free} >> start);
  assign low  = rot & (~rot + NUM_SLOTS'(1));
  assign pick = NUM_SLOTS'(({low, low} << start) >> NUM_SLOTS);
endmodule

// File: rtl/bullet_fire_sched.sv
// bullet_fire_sched: frame-clocked fire scheduler for the ship's bullet pool.
// Ports: clk_60hz (frame clock), reset (sync, active-high), shoot_up/shoot_down (fire levels),
//        ship_x (ship X), slot_in_use (per-bullet busy flags) -> fire (one-hot start pulse),
//        fire_dir (1=up), fire_x (launch X), busy (FIRE or COOLDOWN), drop_cnt (saturating drops).
// Build option: BULLET_SCHED_RR_EN selects round-robin slot allocation instead of lowest-index.
module bullet_fire_sched
  import bullet_fire_sched_pkg::*;
#(
  parameter int NUM_SLOTS       = DEF_NUM_SLOTS,
  parameter int COOLDOWN_FRAMES = DEF_COOLDOWN_FRAMES,
  parameter int X_W             = 10
) (
  input  logic                 clk_60hz,
  input  logic                 reset,
  input  logic                 shoot_up,
  input  logic                 shoot_down,
  input  logic [X_W-1:0]       ship_x,
  input  logic [NUM_SLOTS-1:0] slot_in_use,
  output logic [NUM_SLOTS-1:0] fire,
  output logic                 fire_dir,
  output logic [X_W-1:0]       fire_x,
  output logic                 busy,
  output logic [7:0]           drop_cnt
);
  localparam int CW = $clog2(COOLDOWN_FRAMES + 1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(COOLDOWN_FRAMES - 1);
  state_t state;
  logic up_q, dn_q, up_e, dn_e, req, dir, pending;
  logic [CW-1:0] cnt;
  logic [NUM_SLOTS-1:0] resv, free, pick;
  logic [1:0] resv_age;
  logic [2:0] start;
  assign up_e = shoot_up & ~up_q;
  assign dn_e = shoot_down & ~dn_q;
  assign req  = up_e | dn_e;
  assign free = ~slot_in_use & ~resv;
  assign busy = state != IDLE;
`ifdef BULLET_SCHED_RR_EN
  logic [2:0] ptr;
  assign start = ptr;
  always_ff @(posedge clk_60hz)
    if (reset) ptr <= '0;
    else if (state == FIRE && free != '0)
      ptr <= onehot_idx(8'(pick)) == 3'(NUM_SLOTS - 1) ? 3'd0 : onehot_idx(8'(pick)) + 3'd1;
`else
  assign start = '0;
`endif
  bullet_fire_sched_slot_picker #(.NUM_SLOTS(NUM_SLOTS)) u_picker (
    .free (free),
    .start(start),
    .pick (pick)
  );
  always_ff @(posedge clk_60hz) begin
    if (reset) begin
      state    <= IDLE;
      up_q     <= 1'b0;
      dn_q     <= 1'b0;
      dir      <= DIR_UP;
      pending  <= 1'b0;
      cnt      <= '0;
      resv     <= '0;
      resv_age <= '0;
      fire     <= '0;
      fire_dir <= DIR_UP;
      fire_x   <= '0;
      drop_cnt <= '0;
    end else begin
      up_q <= shoot_up;
      dn_q <= shoot_down;
      fire <= '0;
      // The just-fired slot stays blocked until its bullet reports in-use or two frames pass.
      if (resv != '0) begin
        resv_age <= resv_age - 2'd1;
        if ((resv & slot_in_use) != '0 || resv_age == 2'd1) resv <= '0;
      end
      case (state)
        IDLE:
          if (req || pending) begin
            state   <= FIRE;
            pending <= 1'b0;
            if (req) dir <= up_e ? DIR_UP : DIR_DOWN;
          end
        FIRE: begin
          // A request arriving now is for the next shot; this shot keeps the old direction.
          if (req) begin
            pending <= 1'b1;
            dir     <= up_e ? DIR_UP : DIR_DOWN;
          end
          if (free != '0) begin
            fire     <= pick;
            fire_x   <= ship_x;
            fire_dir <= dir;
            resv     <= pick;
            resv_age <= 2'd2;
            cnt      <= CNT_LOAD;
            state    <= COOLDOWN;
          end else begin
            drop_cnt <= drop_cnt + 8'(drop_cnt != 8'hff);
            state    <= IDLE;
          end
        end
        COOLDOWN: begin
          if (req) dir <= up_e ? DIR_UP : DIR_DOWN;
          if (cnt != '0) begin
            cnt <= cnt - CW'(1);
            if (req) pending <= 1'b1;
          end else begin
            // A request landing on the final cooldown frame is served like a pending one.
            state   <= (pending || req) ? FIRE : IDLE;
            pending <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_bullet_fire_sched.sv
// tb_bullet_fire_sched: directed scenarios plus a randomized run against a time-based model.
module tb_bullet_fire_sched;
  localparam int NS = 4;
  localparam int CF = 8;
  localparam int XW = 10;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic shoot_up = 1'b0;
  logic shoot_down = 1'b0;
  logic [XW-1:0] ship_x = '0;
  logic [NS-1:0] slot_in_use = '0;
  logic [NS-1:0] fire;
  logic fire_dir;
  logic [XW-1:0] fire_x;
  logic busy;
  logic [7:0] drop_cnt;
  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  bullet_fire_sched #(.NUM_SLOTS(NS), .COOLDOWN_FRAMES(CF), .X_W(XW)) dut (
    .clk_60hz   (clk),
    .reset      (reset),
    .shoot_up   (shoot_up),
    .shoot_down (shoot_down),
    .ship_x     (ship_x),
    .slot_in_use(slot_in_use),
    .fire       (fire),
    .fire_dir   (fire_dir),
    .fire_x     (fire_x),
    .busy       (busy),
    .drop_cnt   (drop_cnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    shoot_up = 1'b0;
    shoot_down = 1'b0;
    ship_x = '0;
    slot_in_use = '0;
    repeat (3) tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if (fire !== '0) begin n_fail++; $display("FAIL reset_fire: got %b want 0000", fire); end
    n_cmp++; if (fire_dir !== 1'b1) begin n_fail++; $display("FAIL reset_dir: got %b want 1", fire_dir); end
    n_cmp++; if (fire_x !== '0) begin n_fail++; $display("FAIL reset_x: got %0d want 0", fire_x); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if (drop_cnt !== 8'd0) begin n_fail++; $display("FAIL reset_drop: got %0d want 0", drop_cnt); end
  endtask

  task automatic test_first_shot();
    do_reset();
    ship_x = 10'd320;
    shoot_up = 1'b1;
    tick();
    n_cmp++; if (fire !== '0 || busy !== 1'b1) begin n_fail++; $display("FAIL first_lat1: fire=%b busy=%b want 0000/1", fire, busy); end
    tick();
    n_cmp++; if (fire !== 4'b0001) begin n_fail++; $display("FAIL first_fire: got %b want 0001", fire); end
    n_cmp++; if (fire_dir !== 1'b1 || fire_x !== 10'd320) begin n_fail++; $display("FAIL first_dir_x: dir=%b x=%0d want 1/320", fire_dir, fire_x); end
    ship_x = 10'd77;
    tick();
    n_cmp++; if (fire !== '0 || fire_x !== 10'd320 || busy !== 1'b1) begin n_fail++; $display("FAIL first_width: fire=%b x=%0d busy=%b want 0000/320/1", fire, fire_x, busy); end
  endtask

  task automatic test_pending();
    int t1, t2, pulses;
    logic [NS-1:0] f2;
    logic d2;
    logic [XW-1:0] x2;
    do_reset();
    ship_x = 10'd320;
    shoot_up = 1'b1;
    tick();
    tick();
    t1 = cyc;
    slot_in_use = 4'b0001;
    ship_x = 10'd100;
    tick();
    tick();
    shoot_down = 1'b1;
    t2 = -1; pulses = 0; f2 = '0; d2 = 1'b1; x2 = '0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (fire != '0) begin
        pulses++;
        if (t2 < 0) begin t2 = cyc; f2 = fire; d2 = fire_dir; x2 = fire_x; end
      end
    end
    n_cmp++; if (t2 - t1 != CF + 1) begin n_fail++; $display("FAIL pend_spacing: got %0d want %0d", t2 - t1, CF + 1); end
    n_cmp++; if (f2 !== 4'b0010 || d2 !== 1'b0) begin n_fail++; $display("FAIL pend_fire: fire=%b dir=%b want 0010/0", f2, d2); end
    n_cmp++; if (x2 !== 10'd100) begin n_fail++; $display("FAIL pend_x: got %0d want 100", x2); end
    n_cmp++; if (pulses != 1) begin n_fail++; $display("FAIL pend_width: got %0d pulse cycles want 1", pulses); end
  endtask

  task automatic test_drop();
    int fired;
    do_reset();
    slot_in_use = 4'b1111;
    shoot_up = 1'b1;
    tick();
    tick();
    n_cmp++; if (fire !== '0 || drop_cnt !== 8'd1 || busy !== 1'b0) begin n_fail++; $display("FAIL drop_one: fire=%b drop=%0d busy=%b want 0000/1/0", fire, drop_cnt, busy); end
    fired = 0;
    for (int i = 0; i < 300; i++) begin
      shoot_up = 1'b0;
      tick();
      if (fire != '0) fired++;
      shoot_up = 1'b1;
      tick();
      if (fire != '0) fired++;
      if (i == 9) begin
        n_cmp++; if (drop_cnt !== 8'd10) begin n_fail++; $display("FAIL drop_count: got %0d want 10", drop_cnt); end
      end
    end
    tick();
    n_cmp++; if (drop_cnt !== 8'd255) begin n_fail++; $display("FAIL drop_sat: got %0d want 255", drop_cnt); end
    n_cmp++; if (fired != 0) begin n_fail++; $display("FAIL drop_nofire: got %0d pulses want 0", fired); end
  endtask

  task automatic test_simultaneous();
    int pulses;
    do_reset();
    ship_x = 10'd512;
    shoot_up = 1'b1;
    shoot_down = 1'b1;
    tick();
    tick();
    n_cmp++; if (fire !== 4'b0001 || fire_dir !== 1'b1) begin n_fail++; $display("FAIL simul_fire: fire=%b dir=%b want 0001/1", fire, fire_dir); end
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (fire != '0) pulses++;
    end
    n_cmp++; if (pulses != 0) begin n_fail++; $display("FAIL simul_single: got %0d extra pulses want 0", pulses); end
  endtask

  task automatic test_rr();
    logic [NS-1:0] want [3];
`ifdef BULLET_SCHED_RR_EN
    want = '{4'b0001, 4'b0010, 4'b0100};
`else
    want = '{4'b0001, 4'b0001, 4'b0001};
`endif
    do_reset();
    for (int j = 0; j < 3; j++) begin
      shoot_up = 1'b1;
      tick();
      tick();
      n_cmp++; if (fire !== want[j]) begin n_fail++; $display("FAIL alloc_%0d: got %b want %b", j, fire, want[j]); end
      shoot_up = 1'b0;
      repeat (12) tick();
    end
  endtask

  task automatic test_reset_mid();
    int pulses;
    do_reset();
    ship_x = 10'd200;
    shoot_up = 1'b1;
    tick();
    shoot_down = 1'b1;
    tick();
    n_cmp++; if (fire !== 4'b0001) begin n_fail++; $display("FAIL rmid_pre: got %b want 0001", fire); end
    reset = 1'b1;
    shoot_up = 1'b0;
    shoot_down = 1'b0;
    tick();
    n_cmp++; if (fire !== '0 || busy !== 1'b0 || fire_dir !== 1'b1 || fire_x !== '0 || drop_cnt !== 8'd0) begin
      n_fail++; $display("FAIL rmid_clear: fire=%b busy=%b dir=%b x=%0d drop=%0d want 0000/0/1/0/0", fire, busy, fire_dir, fire_x, drop_cnt);
    end
    reset = 1'b0;
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (fire != '0 || busy) pulses++;
    end
    n_cmp++; if (pulses != 0) begin n_fail++; $display("FAIL rmid_quiet: got %0d active cycles want 0", pulses); end
  endtask

  // Model: a shot attempt is scheduled at a frame index; a success starts a cooldown that
  // ends CF frames later, and bullets (modelled here) report in-use 2 frames after launch.
  task automatic test_random();
    int attempt, cool_end, ptr, mdrop, hit, s;
    int life_s [NS];
    int life_e [NS];
    logic pu, pd, mdir, edir, pend, req, upe, eb;
    logic [XW-1:0] ex;
    logic [NS-1:0] efire, use_now;
    attempt = -1; cool_end = -1; ptr = 0; mdrop = 0;
    pu = 1'b0; pd = 1'b0; mdir = 1'b1; edir = 1'b1; pend = 1'b0; ex = '0;
    for (int i = 0; i < NS; i++) begin life_s[i] = 0; life_e[i] = 0; end
    do_reset();
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 3) == 0) shoot_up = ~shoot_up;
      if ($urandom_range(0, 3) == 0) shoot_down = ~shoot_down;
      ship_x = XW'($urandom);
      use_now = '0;
      for (int i = 0; i < NS; i++)
        if (k >= life_s[i] && k < life_e[i]) use_now = use_now | (NS'(1) << i);
      slot_in_use = use_now;
      tick();
      req = (shoot_up & ~pu) | (shoot_down & ~pd);
      upe = shoot_up & ~pu;
      pu = shoot_up;
      pd = shoot_down;
      efire = '0;
      if (attempt == k) begin
        hit = -1;
        for (int o = 0; o < NS; o++) begin
          s = (ptr + o) % NS;
          if (hit < 0 && (use_now & (NS'(1) << s)) == '0) hit = s;
        end
        if (hit >= 0) begin
          efire = NS'(1) << hit;
          edir = mdir;
          ex = ship_x;
          cool_end = k + CF;
          life_s[hit] = k + 2;
          life_e[hit] = k + 2 + int'($urandom_range(4, 60));
`ifdef BULLET_SCHED_RR_EN
          ptr = (hit + 1) % NS;
`endif
        end else if (mdrop < 255) mdrop++;
        if (req) begin pend = 1'b1; mdir = upe; end
      end else if (k < cool_end) begin
        if (req) begin pend = 1'b1; mdir = upe; end
      end else if (k == cool_end) begin
        if (req) mdir = upe;
        if (pend || req) attempt = k + 1;
        pend = 1'b0;
      end else if (req || pend) begin
        attempt = k + 1;
        pend = 1'b0;
        if (req) mdir = upe;
      end
      eb = (attempt == k + 1) || (k + 1 <= cool_end);
      n_cmp++;
      if (fire !== efire || fire_dir !== edir || fire_x !== ex || busy !== eb || drop_cnt !== 8'(mdrop)) begin
        n_fail++;
        $display("FAIL random k=%0d: fire=%b dir=%b x=%0d busy=%b drop=%0d, want fire=%b dir=%b x=%0d busy=%b drop=%0d",
                 k, fire, fire_dir, fire_x, busy, drop_cnt, efire, edir, ex, eb, mdrop);
      end
    end
  endtask

  initial begin
    test_reset();
    test_first_shot();
    test_pending();
    test_drop();
    test_simultaneous();
    test_rr();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
